// File: rtl/stopwatch_up.sv
// Count-up MM:SS stopwatch with lap hold, clear and terminal-count LED.
// Four BCD digits drive the shared 7-segment display; count saturates at MAX_MIN:59.
module stopwatch_up #(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] D0,
  output logic [3:0] D1,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic       running,
  output logic       lap_hold,
  output logic       LED
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [15:0] TERM = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 4'd5, 4'd9};

  state_t      state_q, state_d;
  logic [15:0] live_q, live_d;
  logic [15:0] lap_val_q, lap_val_d;
  logic        lap_hold_q, lap_hold_d;
  logic        ss_q, lap_btn_q, clr_q;
  logic        ss_edge, lap_edge, clr_edge;
  logic [15:0] live_inc;

  // BCD ripple increment: ss units -> ss tens (0..5) -> mm units -> mm tens
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = v[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign ss_edge  = start_stop & ~ss_q;
  assign lap_edge = lap & ~lap_btn_q;
  assign clr_edge = clear & ~clr_q;
  assign live_inc = bcd_inc(live_q);

  always_comb begin
    state_d    = state_q;
    live_d     = live_q;
    lap_val_d  = lap_val_q;
    lap_hold_d = lap_hold_q;
    case (state_q)
      IDLE: begin
        if (ss_edge) begin
          state_d = RUN;
        end else if (clr_edge) begin
          live_d = '0;
        end
      end
      RUN: begin
        if (lap_edge) begin
          if (lap_hold_q) begin
            lap_hold_d = 1'b0;
          end else begin
            lap_val_d  = live_q;
            lap_hold_d = 1'b1;
          end
        end
        if (ss_edge) begin
          state_d = PAUSE;
        end
        // Reaching the terminal value overrides a simultaneous stop request
        if (tick) begin
          live_d = live_inc;
          if (live_inc == TERM) begin
            state_d    = DONE;
            lap_hold_d = 1'b0;
          end
        end
      end
      PAUSE: begin
        if (clr_edge) begin
          state_d    = IDLE;
          live_d     = '0;
          lap_hold_d = 1'b0;
        end else begin
          if (ss_edge) begin
            state_d = RUN;
          end
          if (lap_edge && lap_hold_q) begin
            lap_hold_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (clr_edge) begin
          state_d    = IDLE;
          live_d     = '0;
          lap_hold_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Button history resets high so a button held through reset does not fire
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      live_q     <= '0;
      lap_val_q  <= '0;
      lap_hold_q <= 1'b0;
      ss_q       <= 1'b1;
      lap_btn_q  <= 1'b1;
      clr_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      lap_val_q  <= lap_val_d;
      lap_hold_q <= lap_hold_d;
      ss_q       <= start_stop;
      lap_btn_q  <= lap;
      clr_q      <= clear;
    end
  end

  assign {D3, D2, D1, D0} = lap_hold_q ? lap_val_q : live_q;
  assign running          = (state_q == RUN);
  assign lap_hold         = lap_hold_q;
  assign LED              = (state_q == DONE);

endmodule

// File: tb/tb_stopwatch_up.sv
// Directed self-checking bench for stopwatch_up: a default (MAX_MIN=99) instance
// and a MAX_MIN=2 instance for the terminal-count behaviour.
module tb_stopwatch_up;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_tick = 0, a_ss = 0, a_lap = 0, a_clr = 0;
  logic b_tick = 0, b_ss = 0, b_lap = 0, b_clr = 0;
  logic [3:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
  logic a_run, a_hold, a_led, b_run, b_hold, b_led;
  logic [15:0] a_disp, b_disp;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_up dut_a (
    .clk(clk), .reset(reset), .tick(a_tick), .start_stop(a_ss), .lap(a_lap), .clear(a_clr),
    .D0(a_d0), .D1(a_d1), .D2(a_d2), .D3(a_d3),
    .running(a_run), .lap_hold(a_hold), .LED(a_led)
  );

  stopwatch_up #(.MAX_MIN(2)) dut_b (
    .clk(clk), .reset(reset), .tick(b_tick), .start_stop(b_ss), .lap(b_lap), .clear(b_clr),
    .D0(b_d0), .D1(b_d1), .D2(b_d2), .D3(b_d3),
    .running(b_run), .lap_hold(b_hold), .LED(b_led)
  );

  assign a_disp = {a_d3, a_d2, a_d1, a_d0};
  assign b_disp = {b_d3, b_d2, b_d1, b_d0};

  // Drive one clock cycle on instance a (w=0) or b (w=1); returns at the next negedge
  task automatic step(input bit w, input logic t, input logic s, input logic l, input logic c);
    if (!w) begin
      a_tick = t; a_ss = s; a_lap = l; a_clr = c;
    end else begin
      b_tick = t; b_ss = s; b_lap = l; b_clr = c;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input bit w, input int n);
    for (int i = 0; i < n; i++) step(w, 1'b1, 1'b0, 1'b0, 1'b0);
    step(w, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    n_checks++;
    if ({a_disp, a_run, a_hold, a_led} !== 19'h0) begin
      $display("[TB] FAIL reset_state: got disp=%h run=%b hold=%b led=%b expected all zero", a_disp, a_run, a_hold, a_led);
      n_fail++;
    end
    n_checks++;
    if ({b_disp, b_run, b_hold, b_led} !== 19'h0) begin
      $display("[TB] FAIL reset_state_b: got disp=%h run=%b led=%b expected all zero", b_disp, b_run, b_led);
      n_fail++;
    end
    reset = 1'b1;
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (a_run !== 1'b0) begin
      $display("[TB] FAIL held_ss_after_reset: got running=%b expected 0", a_run);
      n_fail++;
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if ({a_disp, a_run} !== 17'h0) begin
      $display("[TB] FAIL ss_release_after_reset: got disp=%h running=%b expected 0000/0", a_disp, a_run);
      n_fail++;
    end
  endtask

  task automatic test_start_stop;
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (a_run !== 1'b1) begin
      $display("[TB] FAIL start: got running=%b expected 1", a_run);
      n_fail++;
    end
    ticks(0, 61);
    n_checks++;
    if (a_disp !== 16'h0101 || a_run !== 1'b1) begin
      $display("[TB] FAIL count_61: got disp=%h running=%b expected 0101/1", a_disp, a_run);
      n_fail++;
    end
    step(0, 0, 1, 0, 0);
    ticks(0, 5);
    n_checks++;
    if (a_disp !== 16'h0101 || a_run !== 1'b0) begin
      $display("[TB] FAIL pause_hold: got disp=%h running=%b expected 0101/0", a_disp, a_run);
      n_fail++;
    end
  endtask

  task automatic test_carry;
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (a_disp !== 16'h0000 || a_run !== 1'b0) begin
      $display("[TB] FAIL clear_in_pause: got disp=%h running=%b expected 0000/0", a_disp, a_run);
      n_fail++;
    end
    step(0, 0, 1, 0, 0);
    ticks(0, 599);
    n_checks++;
    if (a_disp !== 16'h0959) begin
      $display("[TB] FAIL count_0959: got %h expected 0959", a_disp);
      n_fail++;
    end
    ticks(0, 1);
    n_checks++;
    if (a_disp !== 16'h1000) begin
      $display("[TB] FAIL carry_1000: got %h expected 1000", a_disp);
      n_fail++;
    end
    ticks(0, 2999);
    n_checks++;
    if (a_disp !== 16'h5959) begin
      $display("[TB] FAIL count_5959: got %h expected 5959", a_disp);
      n_fail++;
    end
    ticks(0, 1);
    n_checks++;
    if (a_disp !== 16'h6000 || a_led !== 1'b0) begin
      $display("[TB] FAIL carry_6000: got disp=%h led=%b expected 6000/0", a_disp, a_led);
      n_fail++;
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_lap;
    step(0, 0, 1, 0, 0);
    ticks(0, 7);
    step(0, 1, 0, 1, 0);
    n_checks++;
    if (a_disp !== 16'h0007 || a_hold !== 1'b1) begin
      $display("[TB] FAIL lap_latch: got disp=%h hold=%b expected 0007/1", a_disp, a_hold);
      n_fail++;
    end
    ticks(0, 4);
    n_checks++;
    if (a_disp !== 16'h0007 || a_run !== 1'b1) begin
      $display("[TB] FAIL lap_frozen: got disp=%h running=%b expected 0007/1", a_disp, a_run);
      n_fail++;
    end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (a_disp !== 16'h0012 || a_hold !== 1'b0) begin
      $display("[TB] FAIL lap_release: got disp=%h hold=%b expected 0012/0", a_disp, a_hold);
      n_fail++;
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (a_disp !== 16'h0012 || a_hold !== 1'b0) begin
      $display("[TB] FAIL lap_in_pause: got disp=%h hold=%b expected 0012/0", a_disp, a_hold);
      n_fail++;
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_terminal;
    step(1, 0, 1, 0, 0);
    ticks(1, 178);
    n_checks++;
    if (b_disp !== 16'h0258 || b_led !== 1'b0) begin
      $display("[TB] FAIL pre_terminal: got disp=%h led=%b expected 0258/0", b_disp, b_led);
      n_fail++;
    end
    ticks(1, 1);
    n_checks++;
    if (b_disp !== 16'h0259 || b_led !== 1'b1 || b_run !== 1'b0) begin
      $display("[TB] FAIL terminal: got disp=%h led=%b run=%b expected 0259/1/0", b_disp, b_led, b_run);
      n_fail++;
    end
    ticks(1, 10);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    n_checks++;
    if (b_disp !== 16'h0259 || b_led !== 1'b1 || b_run !== 1'b0) begin
      $display("[TB] FAIL done_holds: got disp=%h led=%b run=%b expected 0259/1/0", b_disp, b_led, b_run);
      n_fail++;
    end
    step(1, 0, 0, 0, 1);
    n_checks++;
    if (b_disp !== 16'h0000 || b_led !== 1'b0 || b_run !== 1'b0) begin
      $display("[TB] FAIL done_clear: got disp=%h led=%b run=%b expected 0000/0/0", b_disp, b_led, b_run);
      n_fail++;
    end
  endtask

  task automatic test_clear_rules;
    step(0, 0, 1, 0, 0);
    ticks(0, 3);
    step(0, 1, 0, 0, 1);
    n_checks++;
    if (a_disp !== 16'h0004 || a_run !== 1'b1) begin
      $display("[TB] FAIL clear_in_run: got disp=%h running=%b expected 0004/1", a_disp, a_run);
      n_fail++;
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    n_checks++;
    if (a_disp !== 16'h0000 || a_run !== 1'b0) begin
      $display("[TB] FAIL clear_ss_pause: got disp=%h running=%b expected 0000/0", a_disp, a_run);
      n_fail++;
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    n_checks++;
    if (a_disp !== 16'h0000 || a_run !== 1'b1) begin
      $display("[TB] FAIL clear_ss_idle: got disp=%h running=%b expected 0000/1", a_disp, a_run);
      n_fail++;
    end
    ticks(0, 1);
    n_checks++;
    if (a_disp !== 16'h0001) begin
      $display("[TB] FAIL run_after_idle: got %h expected 0001", a_disp);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    step(0, 1, 1, 1, 0);
    n_checks++;
    if (a_disp !== 16'h0001 || a_hold !== 1'b1 || a_run !== 1'b0) begin
      $display("[TB] FAIL stop_lap_tick: got disp=%h hold=%b running=%b expected 0001/1/0", a_disp, a_hold, a_run);
      n_fail++;
    end
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    n_checks++;
    if (a_run !== 1'b1 || a_disp !== 16'h0001) begin
      $display("[TB] FAIL resume_with_tick: got running=%b disp=%h expected 1/0001", a_run, a_disp);
      n_fail++;
    end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (a_disp !== 16'h0002 || a_hold !== 1'b0) begin
      $display("[TB] FAIL no_inc_on_resume: got disp=%h hold=%b expected 0002/0", a_disp, a_hold);
      n_fail++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start_stop();
    test_carry();
    test_lap();
    test_terminal();
    test_clear_rules();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_up.md
Name: stopwatch_up

Overview:
- Count-up MM:SS stopwatch. It is the up-counting counterpart to the team's load-and-count-down timer.
- It takes a 1 Hz clock-enable pulse from the board's one-hertz divider and level button inputs.
- It produces four BCD digits for the existing 4-digit 7-segment display driver.
- It supports start/stop, a lap (split) freeze of the displayed value, clear, and a terminal-count LED.

Parameters:
- MAX_MIN, 99, terminal minutes value (legal range 1..99); the count saturates at MAX_MIN:59.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- tick  input  1  1 Hz enable, one clk cycle wide; counting happens only on cycles with tick=1
- start_stop  input  1  button level; rising edge toggles run/pause
- lap  input  1  button level; rising edge toggles lap hold
- clear  input  1  button level; rising edge zeroes the count
- D0  output  4  seconds units, BCD, displayed value
- D1  output  4  seconds tens, BCD 0..5, displayed value
- D2  output  4  minutes units, BCD, displayed value
- D3  output  4  minutes tens, BCD, displayed value
- running  output  1  high while in RUN
- lap_hold  output  1  high while the display is frozen on a lap value
- LED  output  1  terminal count reached (DONE)

Behaviour:
- Reset applies at a posedge clk when reset=0 and dominates all other inputs:
  - live count = 00:00, lap latch = 00:00, state = IDLE.
  - running, lap_hold and LED = 0; D3..D0 = 0.
  - The button history registers are set to 1, so a button held through reset does not fire on release of reset.
- Edge detection:
  - Each button has one history flop; edge = btn & ~btn_q.
  - The action takes effect at the posedge where the button is first sampled 1, so outputs change 1 cycle after the input rises.
  - Inputs are already synchronised and debounced upstream.
- State machine (IDLE, RUN, PAUSE, DONE):
  - IDLE: start_stop edge -> RUN. lap edge is ignored. clear edge keeps the count at 00:00.
  - RUN: start_stop edge -> PAUSE. clear edge is ignored. The count advances on tick.
  - PAUSE: start_stop edge -> RUN. clear edge -> IDLE with live count 00:00 and lap_hold=0.
  - DONE: start_stop and lap edges are ignored. clear edge -> IDLE with count 00:00 and lap_hold=0.
- Counting:
  - Counting occurs only in RUN on tick=1, as a BCD ripple: D0 9->0 carries into D1; D1 5->0 carries into D2; D2 9->0 carries into D3.
  - The tick that makes the live count equal MAX_MIN:59 also moves the state to DONE.
  - In DONE the count holds at MAX_MIN:59 and further ticks have no effect.
- Lap:
  - In RUN, a lap edge with lap_hold=0 latches the live count (its pre-increment value if tick is also high that cycle) and sets lap_hold=1.
  - A lap edge with lap_hold=1 clears lap_hold, in RUN or PAUSE.
  - In PAUSE, a lap edge with lap_hold=0 is ignored.
  - Entering DONE clears lap_hold, so the terminal value is always displayed.
- Display: D3..D0 show the lap latch when lap_hold=1, otherwise the live count.
  - All outputs come from registers, with no combinational path from the inputs.
- Status outputs: running = (state==RUN); LED = (state==DONE).
- Simultaneous events in one cycle:
  - RUN with tick and a start_stop edge: the increment is applied and the state becomes PAUSE.
  - PAUSE with tick and a start_stop edge: no increment; the state becomes RUN.
  - RUN with a start_stop edge and a lap edge: both take effect.
  - Clear edge together with a start_stop edge in PAUSE: clear wins, giving IDLE.
  - Clear edge together with a start_stop edge in IDLE: start_stop wins, giving RUN from 00:00.
- Digit invariant: the live count never holds a non-BCD digit, and D1 never exceeds 5.

Test Plan:
- Reset with reset=0 for 2 cycles while start_stop is held at 1, then reset=1 and start_stop is released -> state stays IDLE, D=00:00, running=0 throughout.
- start_stop pulse, then 61 ticks -> D3..D0=0,1,0,1 (01:01), running=1. A second start_stop pulse plus 5 more ticks -> still 01:01, running=0.
- Count in RUN to 09:59, then 1 tick -> 10:00. Preload to 59:59 by ticks, then 1 tick -> 60:00 (carry across all four digits).
- In RUN at 00:07, pulse lap together with tick -> lap_hold=1 and D shows 00:07 while the live count reaches 00:12 after 5 more ticks. Pulse lap again -> D=00:12, lap_hold=0.
- MAX_MIN=2, run from 00:00 for 179 ticks -> D=02:59, LED=1, running=0. 10 more ticks plus a start_stop pulse -> unchanged. clear pulse -> 00:00, LED=0, IDLE.
- In RUN, a clear pulse -> ignored (count continues). stop, then clear together with start_stop in the same cycle -> IDLE at 00:00 with running=0.
